// File: rtl/traffic_light_monitor.sv
// Purpose: passive R/G/Y lamp checker; decodes phase, measures phase length, flags protocol violations.
// Latency: lamp change -> smp after 1 edge -> phase/dur/err after 2 edges; err_cnt follows err by one more edge.
// Backpressure: none; purely observes the lamp lines every cycle and never stalls or drives them.
// Build option: define MON_DURATION_CHECK_EN to include the too-short (3) and too-long (4) checks.
module traffic_light_monitor #(
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned R_MIN     = 10,
  parameter int unsigned G_MIN     = 10,
  parameter int unsigned Y_MIN     = 3,
  parameter int unsigned PHASE_MAX = 200
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             R,
  input  logic             G,
  input  logic             Y,
  input  logic             err_clr,
  output logic [1:0]       phase,
  output logic [CNT_W-1:0] dur,
  output logic             dur_valid,
  output logic             err,
  output logic [2:0]       err_code,
  output logic [7:0]       err_cnt
);

  // Encoding doubles as the phase output code.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RED    = 2'b01,
    ST_GREEN  = 2'b10,
    ST_YELLOW = 2'b11
  } state_t;

  localparam logic [2:0] CODE_MULTI = 3'd1;
  localparam logic [2:0] CODE_ORDER = 3'd2;
  localparam logic [2:0] CODE_DARK  = 3'd5;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};

  // smp is {R,G,Y}; smp_prv is the sample one cycle older.
  logic [2:0]       smp;
  logic [2:0]       smp_prv;
  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] cnt_inc;
  logic             first_phase;
  logic             first_phase_nxt;
  logic [CNT_W-1:0] dur_nxt;
  logic             dur_vld_nxt;
  logic             err_nxt;
  logic [2:0]       err_code_nxt;

  logic             smp_multi;
  logic             prv_multi;
  logic             smp_dark;
  state_t           smp_state;

  // Lamp pattern -> phase it denotes; anything not one-hot maps to idle.
  function automatic state_t lamp_state(input logic [2:0] s);
    case (s)
      3'b100:  lamp_state = ST_RED;
      3'b010:  lamp_state = ST_GREEN;
      3'b001:  lamp_state = ST_YELLOW;
      default: lamp_state = ST_IDLE;
    endcase
  endfunction

  // Phase that legally follows the given one.
  function automatic state_t succ_state(input state_t s);
    case (s)
      ST_RED:    succ_state = ST_GREEN;
      ST_GREEN:  succ_state = ST_YELLOW;
      ST_YELLOW: succ_state = ST_RED;
      default:   succ_state = ST_IDLE;
    endcase
  endfunction

`ifdef MON_DURATION_CHECK_EN
  localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(PHASE_MAX);
  localparam logic [2:0]       CODE_SHORT = 3'd3;
  localparam logic [2:0]       CODE_LONG  = 3'd4;

  // Minimum legal length of the phase that is ending.
  function automatic logic [CNT_W-1:0] min_len(input state_t s);
    case (s)
      ST_RED:    min_len = CNT_W'(R_MIN);
      ST_GREEN:  min_len = CNT_W'(G_MIN);
      ST_YELLOW: min_len = CNT_W'(Y_MIN);
      default:   min_len = '0;
    endcase
  endfunction
`else
  // Duration limits and the first-phase exemption only matter to the duration checks.
  logic [31:0] unused_cfg;
  assign unused_cfg = (R_MIN ^ G_MIN ^ Y_MIN ^ PHASE_MAX) ^ {31'd0, first_phase};
`endif

  assign smp_multi = (smp[0] & smp[1]) | (smp[0] & smp[2]) | (smp[1] & smp[2]);
  assign prv_multi = (smp_prv[0] & smp_prv[1]) | (smp_prv[0] & smp_prv[2]) | (smp_prv[1] & smp_prv[2]);
  assign smp_dark  = (smp == 3'b000);
  assign smp_state = lamp_state(smp);
  assign cnt_inc   = (cnt == CNT_SAT) ? cnt : cnt + CNT_ONE;
  assign phase     = state;

  // Register the raw lamp lines and keep one older sample for multi-hot edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      smp     <= 3'b000;
      smp_prv <= 3'b000;
    end else begin
      smp     <= {R, G, Y};
      smp_prv <= smp;
    end
  end

  // Next state, phase counter and violation decode; mutually exclusive branches give the priority order.
  always_comb begin
    state_nxt       = state;
    cnt_nxt         = cnt;
    first_phase_nxt = first_phase;
    dur_nxt         = dur;
    dur_vld_nxt     = 1'b0;
    err_nxt         = 1'b0;
    err_code_nxt    = err_code;

    if (state == ST_IDLE) begin
      cnt_nxt = '0;
      if (smp_multi) begin
        if (!prv_multi) begin
          err_nxt      = 1'b1;
          err_code_nxt = CODE_MULTI;
        end
      end else if (!smp_dark) begin
        // Any one-hot pattern starts a phase; its length may be partial, so it is exempt from the minimum.
        state_nxt       = smp_state;
        cnt_nxt         = CNT_ONE;
        first_phase_nxt = 1'b1;
      end
    end else if (smp_multi) begin
      dur_nxt     = cnt;
      dur_vld_nxt = 1'b1;
      state_nxt   = ST_IDLE;
      cnt_nxt     = '0;
      if (!prv_multi) begin
        err_nxt      = 1'b1;
        err_code_nxt = CODE_MULTI;
      end
    end else if (smp_dark) begin
      dur_nxt      = cnt;
      dur_vld_nxt  = 1'b1;
      state_nxt    = ST_IDLE;
      cnt_nxt      = '0;
      err_nxt      = 1'b1;
      err_code_nxt = CODE_DARK;
    end else if (smp_state == state) begin
      cnt_nxt = cnt_inc;
`ifdef MON_DURATION_CHECK_EN
      // cnt only passes through PHASE_MAX once per phase, so this fires once.
      if (cnt == CNT_MAX) begin
        err_nxt      = 1'b1;
        err_code_nxt = CODE_LONG;
      end
`endif
    end else begin
      // Change to a different one-hot lamp: the ended phase is always reported.
      dur_nxt     = cnt;
      dur_vld_nxt = 1'b1;
      if (smp_state != succ_state(state)) begin
        // Back to idle; idle picks the offending lamp up as a fresh phase next cycle.
        state_nxt    = ST_IDLE;
        cnt_nxt      = '0;
        err_nxt      = 1'b1;
        err_code_nxt = CODE_ORDER;
      end
`ifdef MON_DURATION_CHECK_EN
      else if (!first_phase && (cnt < min_len(state))) begin
        state_nxt    = ST_IDLE;
        cnt_nxt      = '0;
        err_nxt      = 1'b1;
        err_code_nxt = CODE_SHORT;
      end
`endif
      else begin
        state_nxt       = smp_state;
        cnt_nxt         = CNT_ONE;
        first_phase_nxt = 1'b0;
      end
    end
  end

  // FSM state, counter and the registered report outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      first_phase <= 1'b0;
      dur         <= '0;
      dur_valid   <= 1'b0;
      err         <= 1'b0;
      err_code    <= 3'd0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      first_phase <= first_phase_nxt;
      dur         <= dur_nxt;
      dur_valid   <= dur_vld_nxt;
      err         <= err_nxt;
      err_code    <= err_code_nxt;
    end
  end

  // Count visible err pulses; a clear coinciding with a pulse keeps that pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_cnt <= 8'd0;
    end else if (err_clr) begin
      err_cnt <= {7'd0, err};
    end else if (err && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end

endmodule
